lsu_dmem_arb: RTL and testbench

Two-requester arbiter for the core data memory port. Shares one `data_*` interface between the load/store pipeline (requester 0, m0) and a background requester (requester 1, m1, e.g. a revocation sweeper or cache refill engine). It tracks in-order outstanding transactions so each response returns to the requester that issued it. It sits between `ls_pipeline` and the data bus.

---
 rtl/lsu_dmem_arb_if.sv | 76 +++++++
 rtl/lsu_dmem_arb.sv | 162 ++++++++++++++++
 tb/tb_lsu_dmem_arb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_arb_if.sv
// Purpose: bundles the m0/m1 requester ports and the shared data-memory port of lsu_dmem_arb.
// Latency: wires only.
// Backpressure: carries req/gnt handshakes; data_gnt_i stalls whichever requester is selected.
// Ports: m0_* (load/store pipeline), m1_* (background requester), data_* (memory bus),
//        rdata_o (broadcast read data), rsp_unexp_o (sticky unexpected-response flag).
// The slave modport is the arbiter's view; the master modport is the surrounding
// requesters and memory.
interface lsu_dmem_arb_if #(
    parameter int MemW = 32
);
    // requester 0: load/store pipeline
    logic            m0_req_i;
    logic            m0_we_i;
    logic            m0_is_cap_i;
    logic            m0_is_lrsc_i;
    logic [3:0]      m0_be_i;
    logic [31:0]     m0_addr_i;
    logic [MemW-1:0] m0_wdata_i;
    logic            m0_gnt_o;
    logic            m0_rvalid_o;
    logic            m0_err_o;
    logic            m0_sc_resp_o;

    // requester 1: background engine
    logic            m1_req_i;
    logic            m1_we_i;
    logic            m1_is_cap_i;
    logic [3:0]      m1_be_i;
    logic [31:0]     m1_addr_i;
    logic [MemW-1:0] m1_wdata_i;
    logic            m1_gnt_o;
    logic            m1_rvalid_o;
    logic            m1_err_o;

    logic [MemW-1:0] rdata_o;

    // shared data-memory port
    logic            data_req_o;
    logic            data_we_o;
    logic            data_is_cap_o;
    logic            data_is_lrsc_o;
    logic [3:0]      data_be_o;
    logic [31:0]     data_addr_o;
    logic [MemW-1:0] data_wdata_o;
    logic            data_gnt_i;
    logic            data_rvalid_i;
    logic            data_err_i;
    logic            data_sc_resp_i;
    logic [MemW-1:0] data_rdata_i;

    logic            rsp_unexp_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_is_cap_i, m0_is_lrsc_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_err_o, m0_sc_resp_o,
        input  m1_req_i, m1_we_i, m1_is_cap_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_err_o,
        output rdata_o,
        output data_req_o, data_we_o, data_is_cap_o, data_is_lrsc_o, data_be_o,
        output data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_err_i, data_sc_resp_i, data_rdata_i,
        output rsp_unexp_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_is_cap_i, m0_is_lrsc_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_err_o, m0_sc_resp_o,
        output m1_req_i, m1_we_i, m1_is_cap_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_err_o,
        input  rdata_o,
        input  data_req_o, data_we_o, data_is_cap_o, data_is_lrsc_o, data_be_o,
        input  data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_err_i, data_sc_resp_i, data_rdata_i,
        input  rsp_unexp_o
    );
endinterface

// File: rtl/lsu_dmem_arb.sv
// Purpose: two-requester arbiter for the data memory port with in-order response routing.
// Latency: zero-cycle combinational request, grant and response paths; state updates on clk_i.
// Backpressure: requester held while data_gnt_i is low (ownership locked) or the ID FIFO is full.
// Ports: clk_i, rst_ni (async active-low), bus (lsu_dmem_arb_if.slave: m0_*, m1_*, data_*,
//        rdata_o, rsp_unexp_o).
module lsu_dmem_arb #(
    parameter int MaxOutstanding = 2,
    parameter int StarveLimit    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    lsu_dmem_arb_if.slave bus
);
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [3:0] Limit = 4'(StarveLimit);

    // Outstanding-transaction FIFO, kept as a shift register so the head is always slot 0.
    // Each slot holds the issuing requester ID plus a tag marking m0 LR/SC accesses, so the
    // LR/SC fence releases on exactly the response that belongs to the LR/SC grant.
    logic [MaxOutstanding-1:0] fifo_id;
    logic [MaxOutstanding-1:0] fifo_lrsc;
    logic [MaxOutstanding-1:0] id_shift;
    logic [MaxOutstanding-1:0] lrsc_shift;
    logic [CW-1:0]             count;
    logic [CW-1:0]             wr_idx;
    logic [CW-1:0]             lrsc_pend;

    logic       lock;
    logic       lock_id;
    logic [3:0] starve;
    logic       rsp_unexp;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_id;
    logic head_lrsc;
    logic sel_vld;
    logic sel_id;
    logic sel_req;
    logic m0_gnt;
    logic m1_gnt;
    logic m0_rvalid;

    assign empty     = (count == '0);
    assign full      = (count == CW'(MaxOutstanding));
    assign head_id   = fifo_id[0];
    assign head_lrsc = fifo_lrsc[0];

    // Selection. A lock keeps a presented-but-ungranted request on the bus; the starve
    // override and the normal m1 path are both blocked while an LR/SC is in flight.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        if (lock) begin
            sel_vld = 1'b1;
            sel_id  = lock_id;
        end else if (bus.m1_req_i && (starve >= Limit) && (lrsc_pend == '0)) begin
            sel_vld = 1'b1;
            sel_id  = 1'b1;
        end else if (bus.m0_req_i) begin
            sel_vld = 1'b1;
            sel_id  = 1'b0;
        end else if (bus.m1_req_i && (lrsc_pend == '0)) begin
            sel_vld = 1'b1;
            sel_id  = 1'b1;
        end
    end

    assign sel_req = sel_vld & (sel_id ? bus.m1_req_i : bus.m0_req_i);

    // A full FIFO blocks the request even if a response pops this cycle.
    assign bus.data_req_o     = sel_req & ~full;
    assign bus.data_we_o      = sel_id ? bus.m1_we_i     : bus.m0_we_i;
    assign bus.data_is_cap_o  = sel_id ? bus.m1_is_cap_i : bus.m0_is_cap_i;
    assign bus.data_is_lrsc_o = ~sel_id & bus.m0_is_lrsc_i;
    assign bus.data_be_o      = sel_id ? bus.m1_be_i     : bus.m0_be_i;
    assign bus.data_addr_o    = sel_id ? bus.m1_addr_i   : bus.m0_addr_i;
    assign bus.data_wdata_o   = sel_id ? bus.m1_wdata_i  : bus.m0_wdata_i;

    assign push   = bus.data_req_o & bus.data_gnt_i;
    assign pop    = bus.data_rvalid_i & ~empty;
    assign m0_gnt = push & ~sel_id;
    assign m1_gnt = push & sel_id;

    assign bus.m0_gnt_o = m0_gnt;
    assign bus.m1_gnt_o = m1_gnt;

    // Responses route from the FIFO head; a response with nothing outstanding is dropped.
    assign m0_rvalid        = pop & ~head_id;
    assign bus.m0_rvalid_o  = m0_rvalid;
    assign bus.m1_rvalid_o  = pop & head_id;
    assign bus.m0_err_o     = bus.data_err_i & m0_rvalid;
    assign bus.m1_err_o     = bus.data_err_i & pop & head_id;
    assign bus.m0_sc_resp_o = bus.data_sc_resp_i & m0_rvalid;
    assign bus.rdata_o      = bus.data_rdata_i;
    assign bus.rsp_unexp_o  = rsp_unexp;

    // On a simultaneous pop the new entry lands one slot lower, behind the shifted contents.
    assign wr_idx     = count - CW'(pop);
    assign id_shift   = fifo_id >> 1;
    assign lrsc_shift = fifo_lrsc >> 1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count     <= '0;
            fifo_id   <= '0;
            fifo_lrsc <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (push && (CW'(i) == wr_idx)) begin
                    fifo_id[i]   <= sel_id;
                    fifo_lrsc[i] <= ~sel_id & bus.m0_is_lrsc_i;
                end else if (pop) begin
                    fifo_id[i]   <= id_shift[i];
                    fifo_lrsc[i] <= lrsc_shift[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
        end else if (bus.data_req_o && !bus.data_gnt_i) begin
            lock    <= 1'b1;
            lock_id <= sel_id;
        end else if (push) begin
            lock    <= 1'b0;
        end
    end

    // Counts m0 wins while m1 waits; saturates so the override holds until m1 is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve <= '0;
        end else if (m1_gnt || !bus.m1_req_i) begin
            starve <= '0;
        end else if (m0_gnt && (starve < Limit)) begin
            starve <= starve + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lrsc_pend <= '0;
        end else begin
            lrsc_pend <= lrsc_pend + CW'(m0_gnt & bus.m0_is_lrsc_i) - CW'(pop & head_lrsc);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_unexp <= 1'b0;
        end else if (bus.data_rvalid_i && empty) begin
            rsp_unexp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lsu_dmem_arb.sv
// Purpose: self-checking bench for lsu_dmem_arb (MaxOutstanding=2, StarveLimit=4).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: bench drives data_gnt_i directly; expected responses kept in a scoreboard queue.
module tb_lsu_dmem_arb;
    typedef struct packed {
        logic        id;
        logic        err;
        logic        sc;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    lsu_dmem_arb_if #(.MemW(32)) bus ();

    lsu_dmem_arb #(
        .MaxOutstanding(2),
        .StarveLimit(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    function automatic exp_t mk(input logic id, input logic err, input logic sc,
                                input logic [31:0] data);
        exp_t r;
        r.id = id; r.err = err; r.sc = sc; r.data = data;
        return r;
    endfunction

    // {data_req, m0_gnt, m1_gnt}
    function automatic logic [2:0] obs_gnt();
        return {bus.data_req_o, bus.m0_gnt_o, bus.m1_gnt_o};
    endfunction

    // {m0_rvalid, m1_rvalid, m0_err, m1_err, m0_sc_resp, rdata}
    function automatic logic [36:0] obs_rsp();
        return {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_err_o, bus.m1_err_o,
                bus.m0_sc_resp_o, bus.rdata_o};
    endfunction

    function automatic logic [36:0] exp_rsp(input exp_t x);
        return {~x.id, x.id, ~x.id & x.err, x.id & x.err, ~x.id & x.sc, x.data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_is_cap_i = 0; bus.m0_is_lrsc_i = 0;
        bus.m0_be_i = '0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_is_cap_i = 0;
        bus.m1_be_i = '0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0;
        bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_err_i = 0;
        bus.data_sc_resp_i = 0; bus.data_rdata_i = '0;
    endtask

    task automatic test_reset();
        logic [121:0] outs;
        drive_idle();
        rst_n = 1'b0;
        #2;
        outs = {bus.data_req_o, bus.data_we_o, bus.data_is_cap_o, bus.data_is_lrsc_o,
                bus.data_be_o, bus.data_addr_o, bus.data_wdata_o, bus.m0_gnt_o,
                bus.m0_rvalid_o, bus.m0_err_o, bus.m0_sc_resp_o, bus.m1_gnt_o,
                bus.m1_rvalid_o, bus.m1_err_o, bus.rdata_o, bus.rsp_unexp_o};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        outs = {bus.data_req_o, bus.data_we_o, bus.data_is_cap_o, bus.data_is_lrsc_o,
                bus.data_be_o, bus.data_addr_o, bus.data_wdata_o, bus.m0_gnt_o,
                bus.m0_rvalid_o, bus.m0_err_o, bus.m0_sc_resp_o, bus.m1_gnt_o,
                bus.m1_rvalid_o, bus.m1_err_o, bus.rdata_o, bus.rsp_unexp_o};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL post_reset_idle: got %h want 0", outs);
        end
    endtask

    // Both request every cycle: winners are m0 x4, m1, m0 x4, m1 (bit c-1 = m1 wins cycle c).
    task automatic test_starve();
        logic [9:0] win_m1;
        logic       w;
        win_m1 = 10'b10_0001_0000;
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h100;
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h200;
        bus.data_gnt_i = 1;
        for (int c = 1; c <= 10; c++) begin
            w = win_m1[c-1];
            bus.data_rvalid_i = (c > 1);
            bus.data_rdata_i  = 32'hA000 + 32'(c);
            #1;
            n_checks++;
            if (obs_gnt() !== (w ? 3'b101 : 3'b110) ||
                bus.data_addr_o !== (w ? 32'h200 : 32'h100)) begin
                n_fail++;
                $display("FAIL starve_gnt c%0d: got gnt %b addr %h want m1win=%b", c,
                         obs_gnt(), bus.data_addr_o, w);
            end
            if (c > 1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_rsp() !== exp_rsp(e)) begin
                    n_fail++;
                    $display("FAIL starve_rsp c%0d: got %h want %h", c, obs_rsp(), exp_rsp(e));
                end
            end
            exp_q.push_back(mk(w, 1'b0, 1'b0, 32'hA000 + 32'(c + 1)));
            tick();
        end
        bus.m0_req_i = 0; bus.m1_req_i = 0;
        bus.data_rvalid_i = 1; bus.data_rdata_i = 32'hA00B;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs_rsp() !== exp_rsp(e)) begin
            n_fail++; $display("FAIL starve_drain: got %h want %h", obs_rsp(), exp_rsp(e));
        end
        tick();
        drive_idle();
    endtask

    // Ungranted m0 request keeps ownership though m1 also requests.
    task automatic test_lock();
        bus.m0_req_i = 1; bus.m0_we_i = 1; bus.m0_be_i = 4'hF;
        bus.m0_addr_i = 32'h300; bus.m0_wdata_i = 32'h55;
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h400;
        bus.data_gnt_i = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) bus.data_gnt_i = 1;
            #1;
            n_checks++;
            if (obs_gnt() !== ((c == 4) ? 3'b110 : 3'b100) || bus.data_addr_o !== 32'h300 ||
                bus.data_we_o !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_hold c%0d: got gnt %b addr %h we %b", c, obs_gnt(),
                         bus.data_addr_o, bus.data_we_o);
            end
            tick();
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'hB1));
        bus.m0_req_i = 0; bus.m0_we_i = 0;
        #1;
        n_checks++;
        if (obs_gnt() !== 3'b101 || bus.data_addr_o !== 32'h400 || bus.data_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_m1_after: got gnt %b addr %h", obs_gnt(), bus.data_addr_o);
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'hB2));
        tick();
        bus.m1_req_i = 0; bus.data_gnt_i = 0;
        for (int r = 0; r < 2; r++) begin
            bus.data_rvalid_i = 1; bus.data_rdata_i = 32'hB1 + 32'(r);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rsp() !== exp_rsp(e)) begin
                n_fail++; $display("FAIL lock_rsp%0d: got %h want %h", r, obs_rsp(), exp_rsp(e));
            end
            tick();
        end
        drive_idle();
    endtask

    // Two outstanding fill the FIFO; a pop does not release the request in the same cycle.
    task automatic test_full();
        logic [2:0] want [1:5];
        want[1] = 3'b110; want[2] = 3'b110; want[3] = 3'b000; want[4] = 3'b000; want[5] = 3'b110;
        bus.m0_req_i = 1; bus.data_gnt_i = 1;
        for (int c = 1; c <= 5; c++) begin
            bus.m0_addr_i     = (c <= 2) ? 32'h500 + 32'((c - 1) * 4) : 32'h508;
            bus.data_rvalid_i = (c == 4);
            bus.data_rdata_i  = 32'hC1;
            #1;
            n_checks++;
            if (obs_gnt() !== want[c]) begin
                n_fail++; $display("FAIL full_gnt c%0d: got %b want %b", c, obs_gnt(), want[c]);
            end
            if (c == 4) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_rsp() !== exp_rsp(e)) begin
                    n_fail++; $display("FAIL full_rsp: got %h want %h", obs_rsp(), exp_rsp(e));
                end
            end
            if (want[c][1]) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'hC0 + 32'(c)));
            tick();
        end
        bus.m0_req_i = 0; bus.data_gnt_i = 0;
        for (int r = 0; r < 2; r++) begin
            bus.data_rvalid_i = 1; bus.data_rdata_i = (r == 0) ? 32'hC2 : 32'hC5;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rsp() !== exp_rsp(e)) begin
                n_fail++; $display("FAIL full_drain%0d: got %h want %h", r, obs_rsp(), exp_rsp(e));
            end
            tick();
        end
        drive_idle();
    endtask

    // Grants m0, m1, m0; the m1 response carries err; c4 pushes and pops a one-entry FIFO.
    task automatic test_order();
        bus.data_gnt_i = 1;
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h600;
        #1;
        n_checks++;
        if (obs_gnt() !== 3'b110) begin
            n_fail++; $display("FAIL order_g1: got %b want 110", obs_gnt());
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'hD1));
        tick();
        bus.m0_req_i = 0; bus.m1_req_i = 1; bus.m1_addr_i = 32'h700;
        #1;
        n_checks++;
        if (obs_gnt() !== 3'b101) begin
            n_fail++; $display("FAIL order_g2: got %b want 101", obs_gnt());
        end
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'hD2));
        tick();
        bus.m1_req_i = 0; bus.m0_req_i = 1; bus.m0_addr_i = 32'h604;
        for (int c = 3; c <= 5; c++) begin
            if (c == 5) bus.m0_req_i = 0;
            bus.data_rvalid_i = 1;
            bus.data_err_i    = (c == 4);
            bus.data_rdata_i  = 32'hD0 + 32'(c - 2);
            #1;
            n_checks++;
            if (obs_gnt() !== ((c == 4) ? 3'b110 : 3'b000)) begin
                n_fail++; $display("FAIL order_gnt c%0d: got %b", c, obs_gnt());
            end
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rsp() !== exp_rsp(e)) begin
                n_fail++; $display("FAIL order_rsp c%0d: got %h want %h", c, obs_rsp(), exp_rsp(e));
            end
            if (c == 4) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'hD3));
            tick();
        end
        drive_idle();
    endtask

    // LR grant fences m1 until the cycle after the LR response.
    task automatic test_lrsc();
        bus.data_gnt_i = 1;
        bus.m0_req_i = 1; bus.m0_is_lrsc_i = 1; bus.m0_addr_i = 32'h800;
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h900;
        #1;
        n_checks++;
        if (obs_gnt() !== 3'b110 || bus.data_is_lrsc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lrsc_grant: got gnt %b lrsc %b", obs_gnt(), bus.data_is_lrsc_o);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'hE1));
        tick();
        bus.m0_req_i = 0; bus.m0_is_lrsc_i = 0;
        for (int c = 2; c <= 6; c++) begin
            bus.data_rvalid_i  = (c == 6);
            bus.data_sc_resp_i = (c == 6);
            bus.data_rdata_i   = 32'hE1;
            #1;
            n_checks++;
            if (obs_gnt() !== 3'b000) begin
                n_fail++; $display("FAIL lrsc_fence c%0d: got %b want 000", c, obs_gnt());
            end
            if (c == 6) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_rsp() !== exp_rsp(e)) begin
                    n_fail++; $display("FAIL lrsc_rsp: got %h want %h", obs_rsp(), exp_rsp(e));
                end
            end
            tick();
        end
        bus.data_rvalid_i = 0; bus.data_sc_resp_i = 0;
        #1;
        n_checks++;
        if (obs_gnt() !== 3'b101 || bus.data_is_lrsc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lrsc_release: got gnt %b lrsc %b", obs_gnt(), bus.data_is_lrsc_o);
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'hE2));
        tick();
        bus.m1_req_i = 0; bus.data_gnt_i = 0;
        bus.data_rvalid_i = 1; bus.data_rdata_i = 32'hE2;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs_rsp() !== exp_rsp(e)) begin
            n_fail++; $display("FAIL lrsc_m1_rsp: got %h want %h", obs_rsp(), exp_rsp(e));
        end
        tick();
        drive_idle();
    endtask

    // Responses with nothing outstanding, including after a reset mid-transaction.
    task automatic test_unexp();
        bus.data_rvalid_i = 1; bus.data_rdata_i = 32'hF0;
        #1;
        n_checks++;
        if (obs_rsp() !== {5'b0, 32'hF0} || bus.rsp_unexp_o !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_drop: got rsp %h unexp %b", obs_rsp(), bus.rsp_unexp_o);
        end
        tick();
        bus.data_rvalid_i = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.rsp_unexp_o !== 1'b1) begin
                n_fail++; $display("FAIL unexp_sticky c%0d: got %b want 1", c, bus.rsp_unexp_o);
            end
            tick();
        end
        bus.m0_req_i = 1; bus.m0_addr_i = 32'hA00; bus.data_gnt_i = 1;
        #1;
        n_checks++;
        if (obs_gnt() !== 3'b110) begin
            n_fail++; $display("FAIL unexp_pre_grant: got %b want 110", obs_gnt());
        end
        tick();
        drive_idle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_unexp_o !== 1'b0) begin
            n_fail++; $display("FAIL unexp_reset_clear: got %b want 0", bus.rsp_unexp_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.data_rvalid_i = 1; bus.data_rdata_i = 32'hF1;
        #1;
        n_checks++;
        if (obs_rsp() !== {5'b0, 32'hF1}) begin
            n_fail++; $display("FAIL unexp_after_reset_rsp: got %h", obs_rsp());
        end
        tick();
        bus.data_rvalid_i = 0;
        #1;
        n_checks++;
        if (bus.rsp_unexp_o !== 1'b1) begin
            n_fail++; $display("FAIL unexp_after_reset_flag: got %b want 1", bus.rsp_unexp_o);
        end
        tick();
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_starve();
        test_lock();
        test_full();
        test_order();
        test_lrsc();
        test_unexp();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
